// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: operation codes, FSM encoding and
// datapath width, plus small opcode classification helpers.
package exec_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/execute_unit_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply and restoring divide, one
// step per clock for ITER clocks after start.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // done flags the edge that performs the last iteration
    assign done = busy && (count == CW'(ITER - 1));

    // Step arithmetic: hi holds partial product / remainder, lo the multiplier / quotient
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH + 1){1'b0}});
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
    end

    // Operand load and one iteration per clock while busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            count   <= {CW{1'b0}};
            is_div  <= 1'b0;
            operand <= {WIDTH{1'b0}};
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else if (start) begin
            busy    <= 1'b1;
            count   <= {CW{1'b0}};
            is_div  <= op;
            operand <= b;
            hi      <= {WIDTH{1'b0}};
            lo      <= a;
        end else if (busy) begin
            count <= count + 1'b1;
            busy  <= !done;
            if (is_div) begin
                if (!div_diff[WIDTH]) begin
                    hi <= div_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= div_shift[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// MIPS execute stage: single-cycle ALU, HI/LO registers and a busy/done
// handshake around the iterative multiply/divide engine.
module execute_unit #(
    parameter int WIDTH = exec_pkg::WIDTH,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       stage,
    input  logic [4:0]       aluop,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] aluresult,
    output logic [7:0]       memaddress,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    import exec_pkg::*;

    localparam logic [2:0] EXEC_STAGE = 3'd2;

    state_t             state;
    state_t             state_next;
    logic               armed;
    logic               start;
    logic               op_mul;
    logic               op_div;
    logic               div_zero;
    logic               md_start;
    logic               md_busy;
    logic               md_done;
    logic [WIDTH-1:0]   md_hi;
    logic [WIDTH-1:0]   md_lo;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_quot;
    logic               neg_rem;
    logic               div_op;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   alu_value;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   aluresult_next;
    logic               zero_next;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic               busy_next;
    logic               done_next;

    assign start      = (stage == EXEC_STAGE) && (state == S_IDLE) && armed;
    assign op_mul     = is_mul_op(aluop);
    assign op_div     = is_div_op(aluop);
    assign div_zero   = op_div && (operandB == {WIDTH{1'b0}});
    assign md_start   = start && (op_mul || (op_div && !div_zero));
    assign a_neg      = is_signed_op(aluop) && operandA[WIDTH-1];
    assign b_neg      = is_signed_op(aluop) && operandB[WIDTH-1];
    assign mag_a      = a_neg ? -operandA : operandA;
    assign mag_b      = b_neg ? -operandB : operandB;
    assign memaddress = aluresult[7:0];

    muldiv_iter #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_muldiv (
        .clock (clock),
        .reset (reset),
        .start (md_start),
        .op    (op_div),
        .a     (mag_a),
        .b     (mag_b),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // One start per visit to stage 2: re-armed only by an edge outside stage 2
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b1;
        end else if (start) begin
            armed <= 1'b0;
        end else if (stage != EXEC_STAGE) begin
            armed <= 1'b1;
        end
    end

    // Sign fix-up information is captured with the operands at start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            div_op   <= 1'b0;
        end else if (md_start) begin
            neg_quot <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_op   <= op_div;
        end
    end

    // Single-cycle ALU function on the live operands
    always_comb begin
        shamt = operandB[4:0];
        case (aluop)
            OP_ADD:  alu_value = operandA + operandB;
            OP_SUB:  alu_value = operandA - operandB;
            OP_AND:  alu_value = operandA & operandB;
            OP_OR:   alu_value = operandA | operandB;
            OP_XOR:  alu_value = operandA ^ operandB;
            OP_NOR:  alu_value = ~(operandA | operandB);
            OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, $signed(operandA) < $signed(operandB)};
            OP_SLTU: alu_value = {{(WIDTH-1){1'b0}}, operandA < operandB};
            OP_SLL:  alu_value = operandA << shamt;
            OP_SRL:  alu_value = operandA >> shamt;
            OP_SRA:  alu_value = $unsigned($signed(operandA) >>> shamt);
            OP_MFHI: alu_value = hi;
            OP_MFLO: alu_value = lo;
            default: alu_value = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (md_start && op_mul) begin
                    state_next = S_MUL;
                end else if (md_start) begin
                    state_next = S_DIV;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (md_done) begin
                    state_next = S_FIN;
                end else begin
                    state_next = state;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        aluresult_next = aluresult;
        zero_next      = zero;
        hi_next        = hi;
        lo_next        = lo;
        busy_next      = busy;
        done_next      = 1'b0;
        product        = neg_quot ? -{md_hi, md_lo} : {md_hi, md_lo};
        quotient       = neg_quot ? -md_lo : md_lo;
        remainder      = neg_rem ? -md_hi : md_hi;
        case (state)
            S_IDLE: begin
                if (!start) begin
                    busy_next = 1'b0;
                end else if (md_start) begin
                    busy_next = 1'b1;
                end else if (div_zero) begin
                    hi_next   = operandA;
                    lo_next   = {WIDTH{1'b1}};
                    done_next = 1'b1;
                end else begin
                    aluresult_next = alu_value;
                    zero_next      = (alu_value == {WIDTH{1'b0}});
                    done_next      = 1'b1;
                end
            end
            S_MUL, S_DIV: busy_next = 1'b1;
            S_FIN: begin
                busy_next = 1'b0;
                done_next = 1'b1;
                if (div_op) begin
                    hi_next = remainder;
                    lo_next = quotient;
                end else begin
                    hi_next = product[2*WIDTH-1:WIDTH];
                    lo_next = product[WIDTH-1:0];
                end
            end
            default: busy_next = 1'b0;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluresult <= {WIDTH{1'b0}};
            zero      <= 1'b1;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            aluresult <= aluresult_next;
            zero      <= zero_next;
            hi        <= hi_next;
            lo        <= lo_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the multi-cycle MIPS datapath, directly upstream of the data-memory stage. During `stage == 2` it computes the ALU result, which also serves as the word address consumed by memory in `stage == 3`. It also owns the HI/LO registers and an iterative multiply/divide engine. A `busy`/`done` handshake tells the stage sequencer when it may advance from 2 to 3.

## Interface
- `WIDTH`, 32, datapath width (fixed at 32 for MIPS; parameterised only for bench convenience)
- `ITER`, 32, multiply/divide iterations (equals `WIDTH`)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `stage`  in  3  current pipeline stage from the sequencer; the unit acts only in stage 2
- `aluop`  in  5  operation code (see Operation)
- `operandA`  in  32  rs value
- `operandB`  in  32  rt value or sign-extended immediate; `[4:0]` is the shift amount for shifts
- `aluresult`  out  32  registered result
- `memaddress`  out  8  `aluresult[7:0]`, a word address into the 128-word memory
- `zero`  out  1  registered `aluresult == 0`
- `hi`, `lo`  out  32 each  HI/LO registers
- `busy`  out  1  high while a multiply/divide iterates
- `done`  out  1  one-cycle pulse when the result is valid; the sequencer advances stage 2→3 on it

## Operation
- aluop codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA: each shifts `operandA` by `operandB[4:0]`
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU
  - 15 MFHI, 16 MFLO
  - 17–31 reserved: result 0, single-cycle
- ADD/SUB wrap modulo 2^32; no overflow trap.
- FSM states:
  - IDLE: on start, single-cycle ops go to IDLE; MULT/MULTU go to MUL; DIV/DIVU go to DIV, except divide-by-zero, which goes to IDLE.
  - MUL: after `ITER` iterations, go to FIN.
  - DIV: after `ITER` iterations, go to FIN.
  - FIN: write hi/lo, pulse `done`, go to IDLE.
- Start condition: `stage == 2`, state IDLE, and `armed` = 1.
  - `armed` sets on any edge where `stage != 2` and clears on start.
  - This gives exactly one operation per visit to stage 2, even if the sequencer holds stage 2 one extra cycle after `done`.
- Operands are latched at start; later operand changes do not affect an in-flight op.
- MULT/DIV: operate on magnitudes, then fix signs.
  - Product sign = A^B sign.
  - Quotient sign = A^B sign; remainder takes the dividend's sign.
  - Results: MULT gives {hi, lo} = 64-bit product. DIV gives lo = quotient, hi = remainder.
- Divide by zero: single-cycle completion with lo = 32'hFFFFFFFF and hi = `operandA`.
- MUL/DIV ops leave `aluresult` and `zero` unchanged. Non-mul/div ops leave hi/lo unchanged.
- MFHI/MFLO return the current hi/lo. A MFHI/MFLO cannot start while `busy`, so it always reads completed values.

## Timing
- Reset (asynchronous, any time, including mid-iteration): aborts the op.
  - State IDLE, iteration counter 0, `armed` = 1.
  - `aluresult`, `hi`, `lo` = 0; `zero` = 1; `memaddress` = 0; `busy` = 0; `done` = 0.
- Single-cycle op: start at edge E0 writes `aluresult`/`zero`. `done` is high from E0 to E1. Latency 1.
- MUL/DIV:
  - `busy` rises at E0; one iteration per edge E1..E32.
  - E33: FIN writes hi/lo, `busy` falls, `done` is high from E33 to E34. Latency 34.
- Divide by zero: latency 1, `busy` never asserts.
- `done` is never high in the same cycle as `busy`. `stage` changes while `busy` are ignored until FIN.

## Structure
- Shared package `exec_pkg`: aluop localparams, FSM state encoding, `WIDTH`.
- One sub-module, `muldiv_iter`:
  - Does shift-add multiply and restoring divide on unsigned magnitudes.
  - Ports: start, op, a, b → busy, done, hi, lo.
  - Sign handling and the handshake stay in `execute_unit`.

## Test plan
- ADD 5+7, then SUB 3−5 → `aluresult` 12 with `zero` 0, then 32'hFFFFFFFE; `memaddress` 8'h0C then 8'hFE; `done` one cycle each.
- SLT vs SLTU with A = 32'hFFFFFFFF, B = 1 → 1 then 0. SRA of 32'h80000000 by 4 → 32'hF8000000.
- MULT −3×7 → after 34 cycles hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB; `busy` high for exactly 33 cycles; `aluresult` unchanged.
- DIV −7/2 → lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF. DIVU 7/0 → lo = 32'hFFFFFFFF, hi = 7 with latency 1.
- Hold `stage` = 2 for 3 cycles after `done` → no second start. Then leave stage 2 and return → a new op starts.
- Assert `reset` at iteration 10 of MULTU → all outputs at reset values immediately. The next MULTU 65536×65536 after release gives hi = 1, lo = 0.
